// File: rtl/cfg_loader_pkg.sv
// Shared types and register layout for the config-chain loader.
// State encoding, Wishbone register offsets and CTRL/STATUS bit positions.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STAT_ERR      = 31;
  localparam int STAT_DONE     = 30;
  localparam int STAT_BUF_FULL = 29;
  localparam int STAT_BUSY     = 28;

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Wishbone slave bus bundle for the config-chain loader.
// Signal names keep the Caravel port naming so wiring stays obvious.
interface cfg_chain_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/cfg_word_serializer.sv
// One-word buffer feeding a 32-bit shifter that emits SHIFT_W bits per enabled cycle.
// Word input is valid/ready; ready also asserts in the cycle the buffer moves into the shifter.
module cfg_word_serializer #(
  parameter int SHIFT_W = 4,
  parameter int LEN_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               en_i,
  input  logic               word_vld_i,
  input  logic [31:0]        word_dat_i,
  output logic               word_rdy_o,
  output logic               buf_full_o,
  output logic               shift_o,
  output logic [SHIFT_W-1:0] data_o,
  output logic               last_o,
  output logic [LEN_W-1:0]   rem_o
);

  localparam int NSLOT = 32 / SHIFT_W;
  localparam int CNT_W = $clog2(NSLOT + 1);

  logic [31:0]      buf_q, buf_d;
  logic             buf_vld_q, buf_vld_d;
  logic [31:0]      sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             load;
  logic             push;

  always_comb begin
    load       = en_i && (cnt_q == '0) && buf_vld_q;
    shift_o    = en_i && (cnt_q != '0) && (rem_q != '0);
    word_rdy_o = !buf_vld_q || load;
    push       = word_vld_i && word_rdy_o;
    last_o     = shift_o && (rem_q <= LEN_W'(SHIFT_W));
    buf_full_o = buf_vld_q;
    rem_o      = rem_q;
    data_o     = '0;
    // On the final partial shift only the low `remaining` bits carry chain data.
    for (int i = 0; i < SHIFT_W; i++) begin
      data_o[i] = shift_o && sreg_q[i] && (rem_q > LEN_W'(i));
    end
  end

  always_comb begin
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    if (load) begin
      sreg_d    = buf_q;
      cnt_d     = CNT_W'(NSLOT);
      buf_vld_d = 1'b0;
    end
    if (shift_o) begin
      sreg_d = sreg_q >> SHIFT_W;
      cnt_d  = cnt_q - 1'b1;
      rem_d  = last_o ? '0 : rem_q - LEN_W'(SHIFT_W);
    end
    if (push) begin
      buf_d     = word_dat_i;
      buf_vld_d = 1'b1;
    end
    if (start_i) begin
      buf_vld_d = 1'b0;
      sreg_d    = '0;
      cnt_d     = '0;
      rem_d     = len_i;
    end
    if (clr_i) begin
      buf_vld_d = 1'b0;
      sreg_d    = '0;
      cnt_d     = '0;
      rem_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      sreg_q    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
    end else begin
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Wishbone-slave bitstream loader: decodes the register map and sequences shift, latch and done.
// Ack one cycle after acceptance; DATA writes stall (ack withheld) while the word buffer is full.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          SHIFT_W      = 4,
  parameter int          LEN_W        = 20,
  parameter int          LATCH_CYCLES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  cfg_chain_loader_if.slave   wb,
  output logic                cfg_shift_o,
  output logic [SHIFT_W-1:0]  cfg_data_o,
  output logic                cfg_latch_o,
  output logic                busy_o
);

  localparam int LC_W = $clog2(LATCH_CYCLES + 1);

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LC_W-1:0]  lcnt_q, lcnt_d;

  logic             dec, req, ctrl_wr, abort, start, accept;
  logic [1:0]       reg_sel;
  logic             ser_en, ser_clr, ser_start, word_vld, word_rdy;
  logic             buf_full, ser_last;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      status, rdata;
  logic             unused_bits;

  assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0], wb.wbs_dat_i};

  assign dec      = wb.wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign reg_sel  = wb.wbs_adr_i[3:2];
  assign req      = wb.wbs_stb_i && wb.wbs_cyc_i && dec && !ack_q;
  assign ctrl_wr  = req && wb.wbs_we_i && (reg_sel == REG_CTRL);
  assign abort    = ctrl_wr && wb.wbs_dat_i[CTRL_ABORT];
  assign start    = ctrl_wr && wb.wbs_dat_i[CTRL_START] && !wb.wbs_dat_i[CTRL_ABORT];
  // Abort kills shifting in the very cycle it is accepted.
  assign ser_en   = (state_q == ST_SHIFT) && !abort;
  assign word_vld = req && wb.wbs_we_i && (reg_sel == REG_DATA) && (state_q == ST_SHIFT);
  assign accept   = req && !(word_vld && !word_rdy);

  assign busy_o      = (state_q == ST_SHIFT) || (state_q == ST_LATCH);
  assign cfg_latch_o = (state_q == ST_LATCH) && !abort;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

  cfg_word_serializer #(
    .SHIFT_W (SHIFT_W),
    .LEN_W   (LEN_W)
  ) u_ser (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .clr_i      (ser_clr),
    .start_i    (ser_start),
    .len_i      (len_q),
    .en_i       (ser_en),
    .word_vld_i (word_vld),
    .word_dat_i (wb.wbs_dat_i),
    .word_rdy_o (word_rdy),
    .buf_full_o (buf_full),
    .shift_o    (cfg_shift_o),
    .data_o     (cfg_data_o),
    .last_o     (ser_last),
    .rem_o      (remaining)
  );

  always_comb begin
    status                = '0;
    status[LEN_W-1:0]     = remaining;
    status[STAT_ERR]      = err_q;
    status[STAT_DONE]     = done_q;
    status[STAT_BUF_FULL] = buf_full;
    status[STAT_BUSY]     = busy_o;
    case (reg_sel)
      REG_LEN:    rdata = 32'(len_q);
      REG_STATUS: rdata = status;
      default:    rdata = '0;
    endcase
    ack_d = accept;
    dat_d = (accept && !wb.wbs_we_i) ? rdata : '0;
    len_d = (accept && wb.wbs_we_i && (reg_sel == REG_LEN)) ? wb.wbs_dat_i[LEN_W-1:0] : len_q;
  end

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    err_d     = err_q;
    lcnt_d    = lcnt_q;
    ser_clr   = 1'b0;
    ser_start = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      ser_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_d = 1'b0;
            if (len_q != '0) begin
              state_d   = ST_SHIFT;
              done_d    = 1'b0;
              ser_start = 1'b1;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
          if (accept && wb.wbs_we_i && (reg_sel == REG_DATA)) err_d = 1'b1;
        end
        ST_SHIFT: begin
          if (start) err_d = 1'b1;
          // Leftover buffered/shifter bits are dropped as we head into latch.
          if (ser_last || (remaining == '0)) begin
            state_d = ST_LATCH;
            ser_clr = 1'b1;
            lcnt_d  = '0;
          end
        end
        ST_LATCH: begin
          if (start) err_d = 1'b1;
          if (lcnt_q == LC_W'(LATCH_CYCLES - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lcnt_q  <= lcnt_d;
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomized bench for cfg_chain_loader: Wishbone register traffic against a
// bit-stream reference model built from the loaded words and the bit length.
module tb_cfg_chain_loader;
  import cfg_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_shift, cfg_latch, busy;
  logic [3:0] cfg_data;

  always #5 clk = ~clk;

  cfg_chain_loader_if wb();

  cfg_chain_loader #(
    .BASE_ADDR    (BASE),
    .SHIFT_W      (4),
    .LEN_W        (20),
    .LATCH_CYCLES (2)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wb          (wb),
    .cfg_shift_o (cfg_shift),
    .cfg_data_o  (cfg_data),
    .cfg_latch_o (cfg_latch),
    .busy_o      (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Chain monitor: only ever appends, tests take snapshots of the counts.
  logic [3:0] shift_q[$];
  int         latch_cyc = 0;
  int         latch_runs = 0;
  logic       prev_latch = 1'b0;

  always @(negedge clk) begin
    if (cfg_shift) shift_q.push_back(cfg_data);
    if (cfg_latch) begin
      latch_cyc++;
      if (!prev_latch) latch_runs++;
    end
    prev_latch = cfg_latch;
  end

  // Reference model: concatenate words LSB first, keep `len` bits, cut into nibbles.
  logic [31:0] mdl_words[$];
  logic [3:0]  exp_q[$];
  int          last_lat[$];

  function automatic void build_exp(input int len);
    logic [31:0] w;
    logic [3:0]  ch;
    exp_q.delete();
    for (int c = 0; c * 4 < len; c++) begin
      ch = '0;
      for (int b = 0; b < 4; b++) begin
        int idx;
        idx = c * 4 + b;
        if (idx < len) begin
          w = mdl_words[idx / 32];
          ch[b] = w[idx % 32];
        end
      end
      exp_q.push_back(ch);
    end
  endfunction

  task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                         output logic [31:0] rdat, output int lat);
    bit got;
    @(negedge clk);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdat;
    lat  = 0;
    rdat = '0;
    got  = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (wb.wbs_ack_o) begin
        got  = 1'b1;
        rdat = wb.wbs_dat_o;
      end
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    if (!got) check_val("wb_ack_timeout", 32'(wb.wbs_ack_o), 32'd1);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] rd_unused;
    int          lat;
    wb_xfer(BASE | (32'(r) << 2), 1'b1, d, rd_unused, lat);
    last_lat.push_back(lat);
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] d);
    int lat;
    wb_xfer(BASE | (32'(r) << 2), 1'b0, 32'h0, d, lat);
  endtask

  task automatic wait_done(output logic [31:0] st);
    st = '0;
    for (int i = 0; i < 300 && !st[STAT_DONE]; i++) rd(REG_STATUS, st);
  endtask

  // Runs one load of the words already in mdl_words and checks the chain stream.
  task automatic run_load(input string tag, input int len, input int gap_max, input bit dup_start);
    logic [31:0] st;
    int          sb, lb, rb, n;
    wr(REG_LEN, 32'(len));
    rd(REG_LEN, st);
    check_val({tag, "_len_rb"}, st, 32'(len));
    build_exp(len);
    sb = shift_q.size();
    lb = latch_cyc;
    rb = latch_runs;
    last_lat.delete();
    wr(REG_CTRL, 32'h1);
    foreach (mdl_words[k]) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      wr(REG_DATA, mdl_words[k]);
      if (dup_start && k == 0) wr(REG_CTRL, 32'h1);
    end
    wait_done(st);
    repeat (2) @(posedge clk);
    n = shift_q.size() - sb;
    check_val({tag, "_nshift"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check_val($sformatf("%s_d%0d", tag, i), 32'(shift_q[sb + i]), 32'(exp_q[i]));
    check_val({tag, "_latch_cyc"}, 32'(latch_cyc - lb), (len > 0) ? 32'd2 : 32'd0);
    check_val({tag, "_latch_runs"}, 32'(latch_runs - rb), (len > 0) ? 32'd1 : 32'd0);
    check_val({tag, "_status"}, st, dup_start ? 32'hC000_0000 : 32'h4000_0000);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] st;
    bit          acked;
    int          sb, n_at, lb, len;

    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_dat_i = '0;
    wb.wbs_adr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_shift", 32'(cfg_shift), 32'd0);
    check_val("rst_data", 32'(cfg_data), 32'd0);
    check_val("rst_latch", 32'(cfg_latch), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(REG_STATUS, st);
    check_val("rst_status", st, 32'h0);
    rd(REG_LEN, st);
    check_val("rst_len", st, 32'h0);
    @(posedge clk);
    #1;
    check_val("dat_idle_zero", wb.wbs_dat_o, 32'h0);

    // Undecoded address must never be acknowledged.
    @(negedge clk);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_adr_i = BASE + 32'h40;
    acked = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o) acked = 1'b1;
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    check_val("undecoded_ack", 32'(acked), 32'd0);

    wr(REG_DATA, 32'hDEAD_BEEF);
    rd(REG_STATUS, st);
    check_val("err_data_idle", st, 32'h8000_0000);

    mdl_words = '{32'h7654_3210, 32'hFEDC_BA98};
    run_load("len64", 64, 0, 1'b0);

    mdl_words = '{32'h0000_003F};
    run_load("len6", 6, 0, 1'b0);

    mdl_words = '{$urandom, $urandom, $urandom};
    run_load("b2b96", 96, 0, 1'b0);
    check_val("b2b_first_lat", 32'(last_lat[1] <= 2), 32'd1);
    check_val("b2b_third_stall", 32'(last_lat[3] > 2), 32'd1);

    mdl_words = '{$urandom};
    run_load("dupstart", 32, 0, 1'b1);

    mdl_words.delete();
    run_load("len0", 0, 0, 1'b0);

    // Abort mid-shift: the chain must stop and never latch.
    mdl_words = '{$urandom, $urandom};
    wr(REG_LEN, 32'd64);
    sb = shift_q.size();
    lb = latch_cyc;
    wr(REG_CTRL, 32'h1);
    wr(REG_DATA, mdl_words[0]);
    for (int i = 0; i < 50 && (shift_q.size() - sb) < 3; i++) @(posedge clk);
    wr(REG_CTRL, 32'h2);
    n_at = shift_q.size();
    check_val("abort_shift_now", 32'(cfg_shift), 32'd0);
    repeat (6) @(posedge clk);
    check_val("abort_no_more_shift", 32'(shift_q.size()), 32'(n_at));
    check_val("abort_partial", 32'(n_at - sb < 16), 32'd1);
    check_val("abort_no_latch", 32'(latch_cyc - lb), 32'd0);
    rd(REG_STATUS, st);
    check_val("abort_busy_done", st & 32'h5000_0000, 32'h0);
    run_load("after_abort", 64, 2, 1'b0);

    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 160);
      mdl_words.delete();
      for (int w = 0; w < (len + 31) / 32; w++) mdl_words.push_back($urandom);
      run_load($sformatf("rnd%0d", k), len, 12, 1'b0);
    end

    // Asynchronous reset in the middle of a load.
    mdl_words = '{$urandom, $urandom};
    wr(REG_LEN, 32'd64);
    wr(REG_CTRL, 32'h1);
    wr(REG_DATA, mdl_words[0]);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_shift", 32'(cfg_shift), 32'd0);
    check_val("arst_latch", 32'(cfg_latch), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(REG_STATUS, st);
    check_val("arst_status", st, 32'h0);
    rd(REG_LEN, st);
    check_val("arst_len", st, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
